ula_multiciclo: RTL and testbench

//   Multi-cycle 8-bit execute unit directly downstream of the register bank.

---
 rtl/ula_multiciclo.sv | 190 +++++++++++++++++++
 tb/tb_ula_multiciclo.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo.sv
// Multi-cycle 8-bit execute unit feeding the register-bank write port.
// Define ULA_MULDIV_EN to build the iterative MUL/DIV/REM datapath; without it ops 101-111 return 0.
module ula_multiciclo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] dest,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  wd3,
    output logic [ADDR_W-1:0] wa3,
    output logic              we3,
    output logic              zero,
    output logic              div_by_zero,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
`ifdef ULA_MULDIV_EN
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_REM = 3'b111;
    localparam int         CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
`endif

    state_t            state;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] dest_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;

    logic              calc_last;
    logic [WIDTH-1:0]  calc_res;
    logic              calc_dbz;

`ifdef ULA_MULDIV_EN
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  mul_acc;
    logic [WIDTH-1:0]  mul_mcand;
    logic [WIDTH-1:0]  mul_mplier;
    logic [WIDTH-1:0]  mul_acc_next;
    logic [WIDTH-1:0]  div_rem;
    logic [WIDTH-1:0]  div_quo;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH:0]    div_diff;
    logic              div_ge;
    logic [WIDTH-1:0]  div_rem_next;
    logic [WIDTH-1:0]  div_quo_next;
`endif

    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_comb begin
        calc_last = 1'b1;
        calc_res  = '0;
        calc_dbz  = 1'b0;
`ifdef ULA_MULDIV_EN
        mul_acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
        // Restoring step: the remainder always stays below b, so the borrow bit alone decides.
        div_shift    = {div_rem, div_quo[WIDTH-1]};
        div_diff     = div_shift - {1'b0, b_q};
        div_ge       = ~div_diff[WIDTH];
        div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_next = {div_quo[WIDTH-2:0], div_ge};
`endif
        case (op_q)
            OP_ADD: calc_res = a_q + b_q;
            OP_SUB: calc_res = a_q - b_q;
            OP_AND: calc_res = a_q & b_q;
            OP_OR:  calc_res = a_q | b_q;
            OP_XOR: calc_res = a_q ^ b_q;
`ifdef ULA_MULDIV_EN
            OP_MUL: begin
                calc_last = (cnt == LAST);
                calc_res  = mul_acc_next;
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    calc_res = '1;
                    calc_dbz = 1'b1;
                end else begin
                    calc_last = (cnt == LAST);
                    calc_res  = div_quo_next;
                end
            end
            OP_REM: begin
                if (b_q == '0) begin
                    calc_res = a_q;
                    calc_dbz = 1'b1;
                end else begin
                    calc_last = (cnt == LAST);
                    calc_res  = div_rem_next;
                end
            end
`endif
            default: calc_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= '0;
            dest_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            wd3         <= '0;
            wa3         <= '0;
            we3         <= 1'b0;
            done        <= 1'b0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef ULA_MULDIV_EN
            cnt         <= '0;
            mul_acc     <= '0;
            mul_mcand   <= '0;
            mul_mplier  <= '0;
            div_rem     <= '0;
            div_quo     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    we3  <= 1'b0;
                    if (start) begin
                        op_q   <= op;
                        dest_q <= dest;
                        a_q    <= a;
                        b_q    <= b;
`ifdef ULA_MULDIV_EN
                        cnt        <= '0;
                        mul_acc    <= '0;
                        mul_mcand  <= a;
                        mul_mplier <= b;
                        div_rem    <= '0;
                        div_quo    <= a;
`endif
                        state  <= CALC;
                    end
                end
                CALC: begin
`ifdef ULA_MULDIV_EN
                    cnt        <= cnt + 1'b1;
                    mul_acc    <= mul_acc_next;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    div_rem    <= div_rem_next;
                    div_quo    <= div_quo_next;
`endif
                    if (calc_last) begin
                        wd3         <= calc_res;
                        wa3         <= dest_q;
                        zero        <= (calc_res == '0);
                        div_by_zero <= calc_dbz;
                        done        <= 1'b1;
                        // Register 0 is hard-wired; the op still completes with done.
                        we3         <= (dest_q != '0);
                        state       <= WB;
                    end
                end
                WB: begin
                    done  <= 1'b0;
                    we3   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed bench for ula_multiciclo; expectations follow whether ULA_MULDIV_EN is defined.
module tb_ula_multiciclo;

`ifdef ULA_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [2:0] dest = 3'd0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy, done, we3, zero, div_by_zero;
    logic [7:0] wd3;
    logic [2:0] wa3;
    logic [1:0] fsm_state;

    int checks = 0;
    int errors = 0;
    int we3_pulses = 0;
    bit mon_en = 1'b0;

    ula_multiciclo #(.WIDTH(8), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .dest(dest),
        .a(a), .b(b), .busy(busy), .done(done), .wd3(wd3), .wa3(wa3),
        .we3(we3), .zero(zero), .div_by_zero(div_by_zero), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mon_en && we3) we3_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Issues one op, scrambles operands after accept, waits for done and checks the write-back.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] va,
                          input logic [7:0] vb, input logic [2:0] d, input logic [7:0] res,
                          input int lat, input bit dbz);
        int n;
        bit seen;
        logic [7:0] er;
        bit ed;
        int el;
        er = res; ed = dbz; el = lat;
        if (!MD && o >= 3'b101) begin
            er = 8'h00; ed = 1'b0; el = 2;
        end
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb; dest = d;
        @(posedge clk); #1;
        start = 1'b0; a = ~va; b = vb ^ 8'h5A; op = ~o;
        check({tag, "_busy"}, busy, 1);
        n = 1; seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1'b1;
        end
        check({tag, "_lat"}, n, el);
        check({tag, "_wd3"}, wd3, er);
        check({tag, "_wa3"}, wa3, d);
        check({tag, "_we3"}, we3, (d != 3'd0));
        check({tag, "_zero"}, zero, (er == 8'h00));
        check({tag, "_dbz"}, div_by_zero, ed);
        @(posedge clk); #1;
        check({tag, "_done_off"}, {busy, done, we3}, 3'b000);
    endtask

    initial begin
        int pulses;
        int guard;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {busy, done, we3, zero, div_by_zero}, 5'b0);
        check("rst_wd3", {wd3, wa3}, 11'h0);
        @(negedge clk);
        reset = 1'b0;

        run_op("add", 3'b000, 8'hF0, 8'h20, 3'd3, 8'h10, 2, 1'b0);

        // Reset in the middle of a MUL must abort without a write-back.
        mon_en = 1'b1; we3_pulses = 0;
        @(negedge clk);
        start = 1'b1; op = 3'b101; a = 8'h0D; b = 8'h0B; dest = 3'd5;
        @(posedge clk); #1;
        start = 1'b0;
        if (MD) repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_outs", {done, we3, zero, div_by_zero}, 4'b0);
        check("abort_wd3", {wd3, wa3}, 11'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_we3", we3_pulses, 0);
        check("abort_idle", busy, 0);
        mon_en = 1'b0;

        run_op("sub0", 3'b001, 8'h05, 8'h05, 3'd0, 8'h00, 2, 1'b0);
        run_op("subw", 3'b001, 8'h00, 8'h01, 3'd1, 8'hFF, 2, 1'b0);
        run_op("and", 3'b010, 8'hCC, 8'hAA, 3'd2, 8'h88, 2, 1'b0);
        run_op("or", 3'b011, 8'hCC, 8'hAA, 3'd4, 8'hEE, 2, 1'b0);
        run_op("xor", 3'b100, 8'hCC, 8'hAA, 3'd7, 8'h66, 2, 1'b0);
        run_op("mul", 3'b101, 8'h0D, 8'h0B, 3'd5, 8'h8F, 9, 1'b0);
        run_op("mulov", 3'b101, 8'hFF, 8'hFF, 3'd6, 8'h01, 9, 1'b0);
        run_op("div", 3'b110, 8'h64, 8'h07, 3'd1, 8'h0E, 9, 1'b0);
        run_op("rem", 3'b111, 8'h64, 8'h07, 3'd2, 8'h02, 9, 1'b0);
        run_op("div1", 3'b110, 8'hFF, 8'h01, 3'd3, 8'hFF, 9, 1'b0);
        run_op("divsm", 3'b110, 8'h07, 8'h64, 3'd3, 8'h00, 9, 1'b0);
        run_op("remsm", 3'b111, 8'h07, 8'h64, 3'd4, 8'h07, 9, 1'b0);
        run_op("div0", 3'b110, 8'h64, 8'h00, 3'd5, 8'hFF, 2, 1'b1);
        run_op("rem0", 3'b111, 8'h64, 8'h00, 3'd6, 8'h64, 2, 1'b1);

        // start held high: one done per op, the second op sees the changed operands.
        @(negedge clk);
        start = 1'b1; op = 3'b101; a = 8'h03; b = 8'h05; dest = 3'd6;
        @(posedge clk); #1;
        a = 8'hFF; b = 8'hFF;
        pulses = 0;
        for (int i = 1; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (pulses == 1) check("hold_wd3_first", wd3, MD ? 8'h0F : 8'h00);
                else check("hold_wd3_next", wd3, MD ? 8'h01 : 8'h00);
            end
        end
        start = 1'b0;
        check("hold_pulses", pulses, MD ? 2 : 7);
        guard = 0;
        while (busy && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("hold_drain", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
